// File: rtl/prog_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module : prog_ram_pkg
//  Shared types and constants for the program RAM loader and its storage.
//  Rev    : 1.0
// ============================================================================
package prog_ram_pkg;

    localparam int BYTE_W         = 8;
    localparam int FETCH_ERR_DATA = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_1w1r.sv
`default_nettype none
// ============================================================================
//  Module : ram_1w1r
//  Synchronous 1-write/1-read array; registered read, array itself not reset.
//  Rev    : 1.0
// ============================================================================
module ram_1w1r
    import prog_ram_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset so the fetch port starts from a known value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module : prog_ram_loader
//  Program RAM with a byte-serial little-endian loader and a 1-cycle fetch port.
//  Rev    : 1.0
// ============================================================================
module prog_ram_loader
    import prog_ram_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_abort,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err
);

    localparam int                BYTES       = DATA_W / BYTE_W;
    localparam int                BCNT_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCNT_W-1:0] C_LAST_BYTE = BCNT_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   C_DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
    localparam logic [31:0]       C_ADDR_LIM  = 32'(4 * DEPTH);

    state_t              r_state;
    logic [BCNT_W-1:0]   r_byte_cnt;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W-1:0]   r_last_waddr;
    logic [DATA_W-1:0]   r_shreg;
    logic                r_load_done;
    logic                r_fetch_valid;
    logic                r_fetch_err;

    logic [ADDR_W:0]     w_len_eff;
    logic [DATA_W-1:0]   w_word;
    logic                w_word_done;
    logic                w_fetch_acc;
    logic                w_fetch_bad;
    logic [DATA_W-1:0]   w_rdata;

    assign w_len_eff   = (load_len > C_DEPTH_LEN) ? C_DEPTH_LEN : load_len;
    assign w_word_done = (r_state == LOAD) && load_valid && !load_abort
                         && (r_byte_cnt == C_LAST_BYTE);

    // New bytes enter at the top so the first byte of a word ends up in the LSBs.
    generate
        if (BYTES == 1) begin : g_single_byte
            assign w_word = load_byte;
        end else begin : g_multi_byte
            assign w_word = {load_byte, r_shreg[DATA_W-1:BYTE_W]};
        end
    endgenerate

    assign load_ready  = (r_state == LOAD);
    assign load_busy   = (r_state == LOAD);
    assign load_done   = r_load_done;
    assign fetch_ready = (r_state == IDLE);
    assign fetch_valid = r_fetch_valid;
    assign fetch_err   = r_fetch_err;

    assign w_fetch_acc = fetch_req && fetch_ready;
    assign w_fetch_bad = (fetch_addr >= C_ADDR_LIM) || (fetch_addr[1:0] != 2'b00);
    assign fetch_data  = r_fetch_err ? DATA_W'(FETCH_ERR_DATA) : w_rdata;

    ram_1w1r #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (w_word_done),
        .waddr  (r_waddr),
        .wdata  (w_word),
        .re     (w_fetch_acc && !w_fetch_bad),
        .raddr  (fetch_addr[ADDR_W+1:2]),
        .rdata  (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_byte_cnt    <= '0;
            r_waddr       <= '0;
            r_last_waddr  <= '0;
            r_shreg       <= '0;
            r_load_done   <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_load_done   <= 1'b0;
            r_fetch_valid <= w_fetch_acc;
            if (w_fetch_acc) begin
                r_fetch_err <= w_fetch_bad;
            end

            case (r_state)
                IDLE: begin
                    if (load_start) begin
                        r_byte_cnt   <= '0;
                        r_waddr      <= '0;
                        r_shreg      <= '0;
                        r_last_waddr <= ADDR_W'(w_len_eff - 1'b1);
                        if (w_len_eff == '0) begin
                            r_state     <= DONE;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // Abort beats a same-cycle byte; the partial word is dropped.
                    if (load_abort) begin
                        r_state    <= IDLE;
                        r_byte_cnt <= '0;
                        r_shreg    <= '0;
                    end else if (load_valid) begin
                        if (r_byte_cnt == C_LAST_BYTE) begin
                            r_byte_cnt <= '0;
                            r_waddr    <= r_waddr + 1'b1;
                            if (r_waddr == r_last_waddr) begin
                                r_state     <= DONE;
                                r_load_done <= 1'b1;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_shreg    <= w_word;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module : tb_prog_ram_loader
//  Randomised self-checking bench for prog_ram_loader against a word-array model.
//  Rev    : 1.0
// ============================================================================
module tb_prog_ram_loader;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int BYTES  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              load_abort;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_ready;
    logic              load_busy;
    logic              load_done;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_err;

    logic [31:0] model_mem [DEPTH];
    bit          known     [DEPTH];
    logic [7:0]  byte_q    [$];
    logic [31:0] addr_q    [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    prog_ram_loader #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_len    (load_len),
        .load_abort  (load_abort),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .load_ready  (load_ready),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_err   (fetch_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Starts a load and streams its bytes; abort_at < 0 means run to completion.
    task automatic run_load(input int len, input int abort_at, input bit abort_with_byte);
        int         eff;
        int         total;
        logic [7:0] wbuf [BYTES];
        logic [7:0] b;
        eff   = (len > DEPTH) ? DEPTH : len;
        total = eff * BYTES;
        load_len   = (ADDR_W + 1)'(len);
        load_start = 1'b1;
        fetch_req  = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        check("start_busy", 64'(load_busy), 64'(eff != 0));
        check("start_done", 64'(load_done), 64'(eff == 0));
        if (eff == 0) begin
            @(negedge clk);
            check("zero_done_clr", 64'(load_done), 64'(0));
            check("zero_fetch_rdy", 64'(fetch_ready), 64'(1));
            return;
        end
        for (int i = 0; i < total; i++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            repeat (gaps) begin
                load_valid = 1'b0;
                load_byte  = 8'($urandom);
                fetch_req  = 1'($urandom_range(0, 1));
                fetch_addr = 32'(4 * $urandom_range(0, DEPTH - 1));
                @(negedge clk);
                check("gap_ready", 64'(load_ready), 64'(1));
                check("gap_fetch_rdy", 64'(fetch_ready), 64'(0));
                check("gap_fetch_valid", 64'(fetch_valid), 64'(0));
                check("gap_done", 64'(load_done), 64'(0));
            end
            if (i == abort_at) begin
                load_abort = 1'b1;
                load_valid = abort_with_byte;
                load_byte  = 8'($urandom);
                fetch_req  = 1'b0;
                @(negedge clk);
                load_abort = 1'b0;
                load_valid = 1'b0;
                check("abort_busy", 64'(load_busy), 64'(0));
                check("abort_done", 64'(load_done), 64'(0));
                check("abort_fetch_rdy", 64'(fetch_ready), 64'(1));
                return;
            end
            b = (byte_q.size() > 0) ? byte_q.pop_front() : 8'($urandom);
            load_valid = 1'b1;
            load_byte  = b;
            fetch_req  = 1'($urandom_range(0, 1));
            @(negedge clk);
            load_valid = 1'b0;
            fetch_req  = 1'b0;
            wbuf[i % BYTES] = b;
            if (i % BYTES == BYTES - 1) begin
                model_mem[i / BYTES] = {wbuf[3], wbuf[2], wbuf[1], wbuf[0]};
                known[i / BYTES]     = 1'b1;
            end
            check("byte_done", 64'(load_done), 64'(i == total - 1));
            check("byte_busy", 64'(load_busy), 64'(i != total - 1));
            check("byte_fetch_valid", 64'(fetch_valid), 64'(0));
        end
        @(negedge clk);
        check("post_done", 64'(load_done), 64'(0));
        check("post_ready", 64'(load_ready), 64'(0));
    endtask

    // Issues the queued fetch addresses on consecutive cycles.
    task automatic run_fetches();
        logic [31:0] a;
        logic [31:0] exp_data;
        bit          bad;
        bit          chk_data;
        exp_data = '0;
        chk_data = 1'b0;
        while (addr_q.size() > 0) begin
            a          = addr_q.pop_front();
            fetch_req  = 1'b1;
            fetch_addr = a;
            @(negedge clk);
            bad      = (a >= 32'(4 * DEPTH)) || (a[1:0] != 2'b00);
            chk_data = bad || known[a[ADDR_W+1:2]];
            exp_data = bad ? 32'h0 : model_mem[a[ADDR_W+1:2]];
            check("fetch_valid", 64'(fetch_valid), 64'(1));
            check("fetch_err", 64'(fetch_err), 64'(bad));
            if (chk_data) begin
                check("fetch_data", 64'(fetch_data), 64'(exp_data));
            end
        end
        fetch_req = 1'b0;
        @(negedge clk);
        check("fetch_idle_valid", 64'(fetch_valid), 64'(0));
        if (chk_data) begin
            check("fetch_hold", 64'(fetch_data), 64'(exp_data));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        load_len   = '0;
        load_abort = 1'b0;
        load_valid = 1'b0;
        load_byte  = '0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            known[i]     = 1'b0;
            model_mem[i] = '0;
        end
        #3;
        check("rst_busy", 64'(load_busy), 64'(0));
        check("rst_ready", 64'(load_ready), 64'(0));
        check("rst_done", 64'(load_done), 64'(0));
        check("rst_fvalid", 64'(fetch_valid), 64'(0));
        check("rst_fdata", 64'(fetch_data), 64'(0));
        check("rst_ferr", 64'(fetch_err), 64'(0));
        check("rst_frdy", 64'(fetch_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-instruction directed load, then back-to-back fetch
        byte_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(2, -1, 1'b0);
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        @(negedge clk);
        check("dir_w0", 64'(fetch_data), 64'h13);
        fetch_addr = 32'h4;
        @(negedge clk);
        check("dir_w1", 64'(fetch_data), 64'h0010_0093);
        check("dir_w1_valid", 64'(fetch_valid), 64'(1));
        fetch_req = 1'b0;
        @(negedge clk);

        addr_q = '{32'h0, 32'h4, 32'h80, 32'h2, 32'h4};
        run_fetches();

        // Oversized length clamps to the full array
        run_load(40, -1, 1'b0);
        for (int i = 0; i < DEPTH; i++) addr_q.push_back(32'(4 * i));
        run_fetches();

        run_load(0, -1, 1'b0);
        addr_q = '{32'h0, 32'h7C};
        run_fetches();

        // Abort with a byte offered on the 7th byte of a 2-word load
        run_load(2, 6, 1'b1);
        addr_q = '{32'h0, 32'h4, 32'h8};
        run_fetches();

        // Asynchronous reset in the middle of a load
        byte_q = '{8'h44, 8'h33, 8'h22, 8'h11};
        run_load(1, -1, 1'b0);
        addr_q = '{32'h0};
        run_fetches();
        load_len   = (ADDR_W + 1)'(2);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_byte  = 8'hEE;
            @(negedge clk);
        end
        load_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(load_busy), 64'(0));
        check("arst_fdata", 64'(fetch_data), 64'(0));
        check("arst_frdy", 64'(fetch_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(1, -1, 1'b0);
        addr_q = '{32'h0, 32'h4};
        run_fetches();

        // Random loads, aborts and fetches
        repeat (8) begin
            int len;
            int eff;
            int ab;
            len = $urandom_range(0, 40);
            eff = (len > DEPTH) ? DEPTH : len;
            ab  = ($urandom_range(0, 2) == 0 && eff > 0) ? $urandom_range(0, eff * BYTES - 1) : -1;
            run_load(len, ab, 1'($urandom_range(0, 1)));
            repeat (8) begin
                if ($urandom_range(0, 3) == 0) addr_q.push_back($urandom);
                else addr_q.push_back(32'(4 * $urandom_range(0, DEPTH - 1)));
            end
            run_fetches();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
